muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO
//                registers. Shift-add multiply, restoring divide, one
//                iteration per cycle, start/busy/done handshake, MTHI/MTLO.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_next;

  // op[1] selects divide, op[0] selects signed
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mcand;      // multiplicand or divisor magnitude
  logic [WIDTH:0]   p;          // product high half or remainder R
  logic [WIDTH-1:0] q;          // multiplier / quotient shift register
  logic [CNTW-1:0]  cnt;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [WIDTH-1:0] a_orig;     // dividend as presented, for divide-by-zero

  // Operand magnitudes for the launch cycle
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             s_a, s_b;

  // Iteration datapath
  logic [WIDTH:0]   mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH+1:0] div_t;
  logic [WIDTH:0]   p_iter;
  logic [WIDTH-1:0] q_iter;

  // Commit-stage sign fix
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  // Magnitude extraction only applies to signed ops
  always_comb begin
    s_a   = op[0] & a[WIDTH-1];
    s_b   = op[0] & b[WIDTH-1];
    mag_a = s_a ? -a : a;
    mag_b = s_b ? -b : b;
  end

  // One shift-add or restoring-divide step on the current accumulator
  always_comb begin
    mul_add = q[0] ? {1'b0, mcand} : '0;
    mul_sum = {1'b0, p[WIDTH-1:0]} + mul_add;
    div_rs  = {p[WIDTH-1:0], q[WIDTH-1]};
    div_t   = {1'b0, div_rs} - {2'b00, mcand};
    p_iter  = p;
    q_iter  = q;
    if (op_q[1]) begin
      if (!div_t[WIDTH+1]) begin
        p_iter = div_t[WIDTH:0];
        q_iter = {q[WIDTH-2:0], 1'b1};
      end else begin
        p_iter = div_rs;
        q_iter = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      p_iter = {1'b0, mul_sum[WIDTH:1]};
      q_iter = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  // Final result selection with sign correction and divide-by-zero override
  always_comb begin
    prod     = {p[WIDTH-1:0], q};
    prod_fix = (op_q[0] && (sign_a ^ sign_b)) ? -prod : prod;
    quo_fix  = (op_q[0] && (sign_a ^ sign_b)) ? -q : q;
    rem_fix  = (op_q[0] && sign_a) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (div_zero) begin
        hi_res = a_orig;
        lo_res = '1;
      end else begin
        hi_res = rem_fix;
        lo_res = quo_fix;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Registered handshake outputs so no input reaches them combinationally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIN);
    end
  end

  // Operand latch, iteration accumulator, and HI/LO architectural registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      mcand    <= '0;
      p        <= '0;
      q        <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            sign_a   <= s_a;
            sign_b   <= s_b;
            div_zero <= (b == '0);
            a_orig   <= a;
            p        <= '0;
            cnt      <= CNTW'(WIDTH - 1);
            if (op[1]) begin
              q     <= mag_a;
              mcand <= mag_b;
            end else begin
              q     <= mag_b;
              mcand <= mag_a;
            end
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        RUN: begin
          p   <= p_iter;
          q   <= q_iter;
          cnt <= cnt - CNTW'(1);
        end
        FIN: begin
          hi <= hi_res;
          lo <= lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit: stimulus pushes expected
//                {hi,lo}; a monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wd = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] sb[$];

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {hi, lo}, {2*W{1'bx}});
      end else begin
        check("result_hi_lo", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Drive one start pulse; returns just after the sampling edge E0
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp, input bit push);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done with a bound, checking latency and busy profile
  task automatic wait_done(input string name);
    int lat = 0;
    int busy_bad = 0;
    for (int k = 1; k <= W + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (!busy) busy_bad++;
    end
    check({name, "_latency"}, 64'(lat), 64'(W + 1));
    check({name, "_busy_profile"}, {63'd0, busy}, 64'd0);
    if (lat == W + 1) check({name, "_busy_low_cycles"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    launch(o, x, y, {ehi, elo}, 1'b1);
    wait_done(name);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_m4xm4", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h10);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_7_0", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("div_m9_0", DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // MTHI alone in IDLE
    @(negedge clk); hi_we = 1'b1; wd = 32'h1234;
    @(negedge clk); hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});

    // MTHI and MTLO together
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wd = 32'hA5A5;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hA5A5, 32'hA5A5});

    // start together with a write in IDLE: the write must be dropped
    @(negedge clk);
    op = MULTU; a = 32'd2; b = 32'd3; start = 1'b1; hi_we = 1'b1; wd = 32'hDEAD;
    sb.push_back({32'd0, 32'd6});
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("start_beats_mthi", {32'd0, hi}, {32'd0, 32'hA5A5});
    // start and write strobes while busy are ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wd = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("hold_during_op", {hi, lo}, {32'hA5A5, 32'hA5A5});
    begin
      int lat = 0;
      for (int k = 1; k <= W + 8; k++) begin
        @(posedge clk); #1;
        if (done) begin lat = k; break; end
      end
      check("busy_ignore_done_seen", 64'(lat != 0), 64'd1);
    end

    // Reset in the middle of a divide
    launch(DIVU, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_mid_op", {30'd0, busy, done, hi}, 64'd0);
    check("async_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op("multu_3x3_after_reset", MULTU, 32'd3, 32'd3, 32'd0, 32'd9);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
